// File: rtl/shift_seq_pkg.sv
// Shared types and default sizes for the multi-cycle shift sequencer.
package shift_seq_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int CNT_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shifter.sv
// Purpose: single-bit logical shift stage (sel 0 = left, 1 = right), zero fill.
// Latency: combinational.
// Backpressure: none, pure function of a/sel.
module shifter #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic             sel,
    output logic [WIDTH-1:0] y,
    output logic             ovf
);

    always_comb begin
        if (sel) begin
            y   = {1'b0, a[WIDTH-1:1]};
            ovf = 1'b0;
        end else begin
            y   = {a[WIDTH-2:0], 1'b0};
            ovf = a[WIDTH-1];
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Purpose: multi-bit shift by iterating the one-bit shifter; rotate option via SHIFT_SEQ_ROTATE_EN.
// Latency: done pulses amount+1 cycles after the accepting edge.
// Backpressure: start is ignored while busy; no queueing.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic [CNT_W-1:0] amount,
    input  logic             dir,
`ifdef SHIFT_SEQ_ROTATE_EN
    input  logic             rotate,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             overflow
);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   data;
    logic               dir_q;
    logic               ovf_q;
    logic [WIDTH-1:0]   shf_y;
    logic               shf_ovf;
    logic [WIDTH-1:0]   step_y;
    logic               step_ovf;

    shifter #(.WIDTH(WIDTH)) u_shifter (
        .a   (data),
        .sel (dir_q),
        .y   (shf_y),
        .ovf (shf_ovf)
    );

`ifdef SHIFT_SEQ_ROTATE_EN
    logic rot_q;

    // The shifter zero-fills the vacated bit, so OR-ing in the lost bit wraps it.
    always_comb begin
        step_y   = shf_y;
        step_ovf = shf_ovf & ~rot_q;
        if (rot_q) begin
            if (dir_q) step_y[WIDTH-1] = shf_y[WIDTH-1] | data[0];
            else       step_y[0]       = shf_y[0] | data[WIDTH-1];
        end
    end
`else
    assign step_y   = shf_y;
    assign step_ovf = shf_ovf;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            data  <= '0;
            dir_q <= 1'b0;
            ovf_q <= 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
            rot_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        data  <= din;
                        cnt   <= amount;
                        dir_q <= dir;
                        ovf_q <= 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
                        rot_q <= rotate;
`endif
                        state <= (amount != '0) ? SHIFT : DONE;
                    end
                end
                SHIFT: begin
                    data  <= step_y;
                    ovf_q <= ovf_q | step_ovf;
                    cnt   <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign dout     = data;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: latency, busy window, results, ignore-while-busy and reset abort.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] din;
    logic [3:0]  amount;
    logic        dir;
    logic        rotate;
    logic        busy;
    logic        done;
    logic [15:0] dout;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    shift_sequencer #(.WIDTH(16), .CNT_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .din      (din),
        .amount   (amount),
        .dir      (dir),
`ifdef SHIFT_SEQ_ROTATE_EN
        .rotate   (rotate),
`endif
        .busy     (busy),
        .done     (done),
        .dout     (dout),
        .overflow (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Caller is at a negedge that becomes cycle 0; returns at the negedge of the done cycle.
    task automatic run_op(input string tag, input logic [15:0] d, input logic [3:0] amt,
                          input logic dr, input logic rot, input int exp_cyc,
                          input logic [15:0] exp_dout, input logic exp_ovf);
        int  done_cyc = 0;
        bit  busy_ok  = 1'b1;
        start  = 1'b1;
        din    = d;
        amount = amt;
        dir    = dr;
        rotate = rot;
        for (int cyc = 1; cyc <= 20 && done_cyc == 0; cyc++) begin
            @(negedge clk);
            start  = 1'b0;
            din    = 16'hA5A5;
            amount = 4'hF;
            dir    = ~dr;
            rotate = ~rot;
            if (!busy) busy_ok = 1'b0;
            if (done) done_cyc = cyc;
        end
        check({tag, "_done_cycle"}, done_cyc, exp_cyc);
        check({tag, "_busy"}, busy_ok, 1);
        check({tag, "_dout"}, dout, exp_dout);
        check({tag, "_ovf"}, overflow, exp_ovf);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; din = '0; amount = '0; dir = 1'b0; rotate = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dout", dout, 0);
        check("rst_ovf", overflow, 0);
        rst = 1'b0;
        @(negedge clk);

        run_op("shl4", 16'h0001, 4'd4, 1'b0, 1'b0, 5, 16'h0010, 1'b0);
        @(negedge clk);
        check("shl4_idle_after", busy, 0);

        run_op("shl2_ovf", 16'hC000, 4'd2, 1'b0, 1'b0, 3, 16'h0000, 1'b1);
        @(negedge clk);
        run_op("shl3_sticky", 16'h4000, 4'd3, 1'b0, 1'b0, 4, 16'h0000, 1'b1);
        @(negedge clk);
        run_op("shr15", 16'h8001, 4'd15, 1'b1, 1'b0, 16, 16'h0001, 1'b0);
        @(negedge clk);

        // Zero-amount op then back-to-back start in the cycle after done.
        run_op("amt0", 16'hBEEF, 4'd0, 1'b0, 1'b0, 1, 16'hBEEF, 1'b0);
        @(negedge clk);
        check("b2b_idle", busy, 0);
        run_op("b2b_shr1", 16'h1234, 4'd1, 1'b1, 1'b0, 2, 16'h091A, 1'b0);
        @(negedge clk);

        // Start pulsed mid-shift must not disturb the running operation.
        begin
            int done_cyc = 0;
            start = 1'b1; din = 16'h0001; amount = 4'd4; dir = 1'b0; rotate = 1'b0;
            for (int cyc = 1; cyc <= 20 && done_cyc == 0; cyc++) begin
                @(negedge clk);
                start = (cyc == 2);
                din = 16'hFFFF; amount = 4'd1; dir = 1'b1;
                if (done) done_cyc = cyc;
            end
            start = 1'b0;
            check("ignore_done_cycle", done_cyc, 5);
            check("ignore_dout", dout, 16'h0010);
            check("ignore_ovf", overflow, 0);
        end
        @(negedge clk);

        // Reset in cycle 3 of an 8-step shift aborts with no done.
        begin
            bit saw_done = 1'b0;
            start = 1'b1; din = 16'h00FF; amount = 4'd8; dir = 1'b0;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            @(negedge clk);
            check("abort_mid_dout", dout, 16'h03FC);
            rst = 1'b1;
            @(negedge clk);
            check("abort_busy", busy, 0);
            check("abort_done", done, 0);
            check("abort_dout", dout, 0);
            check("abort_ovf", overflow, 0);
            rst = 1'b0;
            for (int cyc = 0; cyc < 12; cyc++) begin
                @(negedge clk);
                if (done || busy) saw_done = 1'b1;
            end
            check("abort_no_done", saw_done, 0);
        end

`ifdef SHIFT_SEQ_ROTATE_EN
        run_op("rotl1", 16'h8001, 4'd1, 1'b0, 1'b1, 2, 16'h0003, 1'b0);
        @(negedge clk);
        run_op("rotr1", 16'h8001, 4'd1, 1'b1, 1'b1, 2, 16'hC000, 1'b0);
        @(negedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle shift controller for the 16-bit ALU. It accepts an operand, a shift amount of 0–15 and a direction. It then iterates the existing single-bit `shifter` stage once per clock until the amount is exhausted. Overflow from each step is accumulated into a sticky flag, so the ALU result mux gets multi-bit shifts from the one-bit datapath.

## Interface
Parameters:
- WIDTH, 16: operand width; must match the `shifter` stage.
- CNT_W, 4: shift-amount width; max amount 2^CNT_W−1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- din  in  WIDTH  operand, captured on accepted start.
- amount  in  CNT_W  number of one-bit steps, captured on accepted start.
- dir  in  1  0 = left, 1 = right (same encoding as `shifter` sel); captured on accepted start.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse; dout/overflow valid.
- dout  out  WIDTH  shifted result; held until next accepted start.
- overflow  out  1  sticky OR of per-step overflow for current operation.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE + start: load data reg ← din, cnt ← amount, dir latched, overflow ← 0.
  - Next state is SHIFT if amount ≠ 0, else DONE.
- SHIFT, once per cycle:
  - data ← shifter(data, dir).
  - overflow ← overflow | step_ovf.
  - cnt ← cnt − 1.
  - At cnt == 1 the step is performed and the next state is DONE.
- DONE: done = 1 for exactly one cycle, then IDLE unconditionally.
- Per-step rules:
  - Left shift: vacated bit is 0; step_ovf = data[WIDTH−1].
  - Right shift: vacated bit is 0; step_ovf = 0, so bits lost off the LSB are not flagged.
- start while busy (SHIFT or DONE): ignored, no queueing; captured inputs are unaffected by input changes mid-operation.
- rst at any time, including mid-shift:
  - State → IDLE; cnt, data, dout, overflow, busy, done all → 0.
  - An aborted operation never produces done.
- dout is the data register; the value is only meaningful from the done cycle onward.

## Timing
- Start accepted at the edge ending cycle 0; done is high in cycle amount+1 (amount=0 → cycle 1; amount=15 → cycle 16).
- busy high from cycle 1 through the done cycle inclusive.
- Back-to-back: a new start is accepted in the cycle after done (IDLE), so minimum issue interval is amount+2 cycles.
- Reset values: busy 0, done 0, dout 0x0000, overflow 0, state IDLE.
- No combinational path from inputs to outputs; all outputs are registered or decoded from the state register.

## Configuration
- SHIFT_SEQ_ROTATE_EN defined:
  - Adds input port `rotate` (1 bit), captured on accepted start.
  - When rotate = 1, each step reinjects the bit shifted out: left → bit 0 ← old bit WIDTH−1; right → bit WIDTH−1 ← old bit 0.
  - Implemented by OR-ing the wrapped bit into the `shifter` output's zero-filled position.
  - overflow is forced to 0 for rotates.
- SHIFT_SEQ_ROTATE_EN undefined: no `rotate` port; logical shifts only, as described above.

## Structure
- Package `shift_seq_pkg`: state enum (IDLE, SHIFT, DONE), WIDTH/CNT_W default constants.
- One sub-module: a single instance of the existing `shifter` as the combinational step (a = data reg, sel = latched dir). Rotate wrap logic sits beside it in this block.
- Everything else (FSM, counter, registers) is in `shift_sequencer` itself.

## Test plan
- din=0x0001, amount=4, dir=0 → done in cycle 5, dout=0x0010, overflow=0, busy high in cycles 1–5.
- din=0xC000, amount=2, dir=0 → dout=0x0000, overflow=1 (sticky across both steps).
- din=0x8001, amount=15, dir=1 → done in cycle 16, dout=0x0001, overflow=0.
- din=0xBEEF, amount=0 → done in cycle 1, dout=0xBEEF; start pulsed in cycle 2 with din=0x1234, amount=1, dir=1 is accepted, giving dout=0x091A in cycle 4.
- Start issued during SHIFT is ignored (result unchanged); rst asserted in cycle 3 of an amount=8 shift → all outputs 0 next cycle, no done ever emitted.
- SHIFT_SEQ_ROTATE_EN build: din=0x8001, amount=1, dir=0, rotate=1 → dout=0x0003, overflow=0; dir=1 → dout=0xC000.
